// File: rtl/tppe_pkg.sv
// Shared constants, count-width helper and packer FSM state type for the TPPE
// sparse-fibre datapath.
package tppe_pkg;

  localparam int BITMASK_WIDTH_DEF = 128;
  localparam int TIMESTEPS_DEF     = 16;
  localparam int ADDR_WIDTH_DEF    = 8;

  // A fibre can hold a non-zero train at every position, so the count needs one bit more than a position.
  function automatic int nnz_width(input int bitmask_width);
    return $clog2(bitmask_width) + 1;
  endfunction

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } packer_state_e;

endpackage

// File: rtl/spike_popcount.sv
// Combinational population count of one spike-train word.
module spike_popcount #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]         data_in,
  output logic [$clog2(WIDTH):0]   count_out
);

  always_comb begin
    count_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_out = count_out + {{$clog2(WIDTH){1'b0}}, data_in[i]};
    end
  end

endmodule

// File: rtl/spike_fibre_packer.sv
// Packs per-neuron spike trains into an occupancy bitmask plus a dense fibre memory.
// Optional spike_total popcount output enabled by SPIKE_FIBRE_PACKER_STATS_EN.
module spike_fibre_packer
  import tppe_pkg::*;
#(
  parameter int BITMASK_WIDTH = BITMASK_WIDTH_DEF,
  parameter int TIMESTEPS     = TIMESTEPS_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TIMESTEPS-1:0]              spike_in,
  input  logic                              spike_valid,
  input  logic                              neuron_last,
  output logic                              spike_ready,
  output logic                              fibre_wr_en,
  output logic [ADDR_WIDTH-1:0]             fibre_wr_addr,
  output logic [TIMESTEPS-1:0]              fibre_wr_data,
  output logic [BITMASK_WIDTH-1:0]          bitmask_out,
  output logic [$clog2(BITMASK_WIDTH):0]    nnz_count,
  output logic                              fibre_valid,
  input  logic                              fibre_ready
`ifdef SPIKE_FIBRE_PACKER_STATS_EN
  ,
  output logic [$clog2(BITMASK_WIDTH*TIMESTEPS):0] spike_total
`endif
);

  localparam int POS_W = $clog2(BITMASK_WIDTH);
  localparam int NNZ_W = nnz_width(BITMASK_WIDTH);

  if (ADDR_WIDTH < POS_W) begin : g_addr_width_check
    $error("ADDR_WIDTH too narrow to address every position of a fibre");
  end

  packer_state_e           state_q, state_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [NNZ_W-1:0]        nnz_q, nnz_d;
  logic [BITMASK_WIDTH-1:0] bitmask_q, bitmask_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [TIMESTEPS-1:0]    wr_data_q, wr_data_d;
  logic                    accept;

  assign accept = spike_valid && (state_q == COLLECT);

`ifdef SPIKE_FIBRE_PACKER_STATS_EN
  localparam int ST_W = $clog2(BITMASK_WIDTH*TIMESTEPS) + 1;
  logic [$clog2(TIMESTEPS):0] pop;
  logic [ST_W-1:0]            total_q, total_d;

  spike_popcount #(.WIDTH(TIMESTEPS)) u_popcount (
    .data_in   (spike_in),
    .count_out (pop)
  );

  always_comb begin
    total_d = total_q;
    if (accept) begin
      total_d = total_q + ST_W'(pop);
    end else if (state_q == EMIT && fibre_ready) begin
      total_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign spike_total = (state_q == EMIT) ? total_q : '0;
`endif

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    nnz_d     = nnz_q;
    bitmask_d = bitmask_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          pos_d = pos_q + POS_W'(1);
          if (spike_in != '0) begin
            bitmask_d[pos_q] = 1'b1;
            wr_en_d          = 1'b1;
            wr_addr_d        = ADDR_WIDTH'(nnz_q[POS_W-1:0]);
            wr_data_d        = spike_in;
            nnz_d            = nnz_q + NNZ_W'(1);
          end
          if (pos_q == POS_W'(BITMASK_WIDTH - 1) || neuron_last) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (fibre_ready) begin
          state_d   = COLLECT;
          pos_d     = '0;
          nnz_d     = '0;
          bitmask_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= COLLECT;
      pos_q     <= '0;
      nnz_q     <= '0;
      bitmask_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      nnz_q     <= nnz_d;
      bitmask_q <= bitmask_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign spike_ready   = (state_q == COLLECT);
  assign fibre_valid   = (state_q == EMIT);
  assign fibre_wr_en   = wr_en_q;
  assign fibre_wr_addr = wr_addr_q;
  assign fibre_wr_data = wr_data_q;
  // Descriptor outputs read zero while a fibre is still being collected.
  assign bitmask_out   = (state_q == EMIT) ? bitmask_q : '0;
  assign nnz_count     = (state_q == EMIT) ? nnz_q : '0;

endmodule
